// File: rtl/a2_bridge_pkg.sv
// rtl/a2_bridge_pkg.sv - shared types and constants for the A2Bridge Apple II-side responder
package a2_bridge_pkg;

    typedef enum logic [1:0] {
        ADDR_LO = 2'd0,
        ADDR_HI = 2'd1,
        DATA    = 2'd2,
        CTRL    = 2'd3
    } bridge_sel_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  data;
    } bus_cycle_t;

    typedef enum logic {
        RST_IDLE   = 1'b0,
        RST_ASSERT = 1'b1
    } reset_state_t;

    localparam int CTRL_RW_N_BIT    = 0;
    localparam int CTRL_RESET_N_BIT = 1;
    localparam int CTRL_ONE0_BIT    = 2;
    localparam int CTRL_ONE1_BIT    = 3;
    localparam int CTRL_DIP_LSB     = 4;

    localparam int HP_LAST       = 13;
    localparam int HP_PHI0_FIRST = 7;

    function automatic logic [7:0] ctrl_byte(input logic [3:0] dip_n, input logic reset_n,
                                             input logic rw_n);
        logic [7:0] b;
        b                      = '0;
        b[CTRL_DIP_LSB +: 4]   = dip_n;
        b[CTRL_ONE1_BIT]       = 1'b1;
        b[CTRL_ONE0_BIT]       = 1'b1;
        b[CTRL_RESET_N_BIT]    = reset_n;
        b[CTRL_RW_N_BIT]       = rw_n;
        return b;
    endfunction

endpackage

// File: rtl/a2_cycle_fifo.sv
// rtl/a2_cycle_fifo.sv - synchronous show-ahead FIFO of bus cycles with count-based full/empty
module a2_cycle_fifo
    import a2_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  bus_cycle_t push_data,
    input  logic       pop,
    output bus_cycle_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bus_cycle_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the same clk frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/a2_bridge_responder.sv
// rtl/a2_bridge_responder.sv - Apple II-side A2Bridge emulator: timebase, cycle replay, bridge reads, reset
module a2_bridge_responder
    import a2_bridge_pkg::*;
#(
    parameter int          HALF_7M_CLKS     = 4,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] IDLE_ADDR        = 16'hFFFF,
    parameter int          RESET_PHI_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_rw_n,
    input  logic [7:0]  cmd_data,
    input  logic [3:0]  dip_switches_n,
    input  logic        reset_req,
    output logic        a2_phi1,
    output logic        a2_7M,
    output logic        a2_reset_n,
    input  logic [1:0]  a2_bridge_sel,
    input  logic        a2_bridge_rd,
    input  logic        a2_bridge_wr,
    input  logic        a2_bridge_bus_d_oe,
    input  logic [7:0]  bridge_d_i,
    output logic [7:0]  bridge_d_o,
    output logic        bridge_d_oe,
    output logic        resp_valid,
    output logic [15:0] resp_addr,
    output logic        resp_rw_n,
    output logic [7:0]  resp_data,
    output logic        resp_driven,
    output logic        contention
);

    localparam int C7_W = (HALF_7M_CLKS > 1) ? $clog2(HALF_7M_CLKS) : 1;
    localparam int RC_W = (RESET_PHI_CYCLES > 1) ? $clog2(RESET_PHI_CYCLES) : 1;
    localparam bus_cycle_t IDLE_CYCLE = {IDLE_ADDR, 1'b1, 8'hFF};

    logic [C7_W-1:0] c7;
    logic [3:0]      hp;
    logic            clk_7m;
    logic            c7_wrap;
    logic            cycle_start;
    logic            phi0;
    logic            card_drive;

    bus_cycle_t      cur;
    bus_cycle_t      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      cap_data;
    logic            cap_driven;
    logic [7:0]      rd_byte;

    reset_state_t    rst_state;
    reset_state_t    rst_state_d;
    logic [RC_W-1:0] rcnt;
    logic [RC_W-1:0] rcnt_d;

    assign c7_wrap     = (c7 == C7_W'(HALF_7M_CLKS - 1));
    assign cycle_start = c7_wrap && (hp == 4'(HP_LAST));
    assign phi0        = (hp >= 4'(HP_PHI0_FIRST));
    assign a2_phi1     = !phi0;
    assign a2_7M       = clk_7m;
    assign card_drive  = a2_bridge_wr && a2_bridge_bus_d_oe;
    assign cmd_ready   = !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c7     <= '0;
            hp     <= '0;
            clk_7m <= 1'b0;
        end else if (c7_wrap) begin
            c7     <= '0;
            clk_7m <= !clk_7m;
            hp     <= (hp == 4'(HP_LAST)) ? 4'd0 : hp + 4'd1;
        end else begin
            c7 <= c7 + 1'b1;
        end
    end

    a2_cycle_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_valid && cmd_ready),
        .push_data({cmd_addr, cmd_rw_n, cmd_data}),
        .pop      (cycle_start),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The outgoing cycle is reported on the same edge that loads the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= IDLE_CYCLE;
            cap_data    <= '0;
            cap_driven  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_addr   <= '0;
            resp_rw_n   <= 1'b0;
            resp_data   <= '0;
            resp_driven <= 1'b0;
        end else begin
            resp_valid <= cycle_start;
            if (cycle_start) begin
                resp_addr   <= cur.addr;
                resp_rw_n   <= cur.rw_n;
                resp_data   <= cap_driven ? cap_data : cur.data;
                resp_driven <= cap_driven;
                cur         <= fifo_empty ? IDLE_CYCLE : fifo_head;
                cap_data    <= '0;
                cap_driven  <= 1'b0;
            end else if (phi0 && card_drive && cur.rw_n) begin
                cap_data   <= bridge_d_i;
                cap_driven <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        case (bridge_sel_t'(a2_bridge_sel))
            ADDR_LO: rd_byte = cur.addr[7:0];
            ADDR_HI: rd_byte = cur.addr[15:8];
            DATA:    rd_byte = cur.data;
            CTRL:    rd_byte = ctrl_byte(dip_switches_n, a2_reset_n, cur.rw_n);
            default: rd_byte = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bridge_d_oe <= 1'b0;
            bridge_d_o  <= '0;
            contention  <= 1'b0;
        end else begin
            if (a2_bridge_rd && !a2_bridge_bus_d_oe) begin
                bridge_d_oe <= 1'b1;
                bridge_d_o  <= rd_byte;
            end else begin
                bridge_d_oe <= 1'b0;
            end
            if ((bridge_d_oe && a2_bridge_bus_d_oe) || (phi0 && card_drive && !cur.rw_n)) begin
                contention <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_state <= RST_IDLE;
            rcnt      <= '0;
        end else begin
            rst_state <= rst_state_d;
            rcnt      <= rcnt_d;
        end
    end

    // A fresh request always restarts the count, even on a cycle-start clk.
    always_comb begin
        rst_state_d = rst_state;
        rcnt_d      = rcnt;
        case (rst_state)
            RST_IDLE: begin
                if (reset_req) begin
                    rst_state_d = RST_ASSERT;
                    rcnt_d      = '0;
                end
            end
            RST_ASSERT: begin
                if (reset_req) begin
                    rcnt_d = '0;
                end else if (cycle_start) begin
                    if (rcnt == RC_W'(RESET_PHI_CYCLES - 1)) begin
                        rst_state_d = RST_IDLE;
                        rcnt_d      = '0;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end
            end
            default: rst_state_d = RST_IDLE;
        endcase
    end

    always_comb begin
        a2_reset_n = 1'b1;
        if (rst_state == RST_ASSERT) begin
            a2_reset_n = 1'b0;
        end
    end

endmodule

// File: doc/a2_bridge_responder.md
# a2_bridge_responder

Synthesizable Apple II-side emulator for the A2Bridge multiplexed interface, used on a bench FPGA to exercise a card's `apple_bus` front end without a real Apple II. It generates `a2_phi1` and `a2_7M` and replays bus cycles from a command FIFO. It answers the card's `a2_bridge_sel`/`a2_bridge_rd` reads with address, data and control bytes, and captures any data the card drives back during phi0.

## Interface
Parameters:
- `HALF_7M_CLKS`, default 4: clk cycles per half period of `a2_7M` (54 MHz gives 6.75 MHz).
- `FIFO_DEPTH`, default 16: command FIFO entries; must be a power of 2.
- `IDLE_ADDR`, default 16'hFFFF: address presented when the FIFO is empty.
- `RESET_PHI_CYCLES`, default 8: phi cycles `a2_reset_n` is held low after `reset_req`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command push handshake.
- `cmd_addr` in 16, `cmd_rw_n` in 1, `cmd_data` in 8: bus cycle to replay.
- `dip_switches_n` in 4: reported in the control byte.
- `reset_req` in 1: one-clk pulse that starts an Apple reset.
- `a2_phi1` out 1, `a2_7M` out 1, `a2_reset_n` out 1.
- `a2_bridge_sel` in 2, `a2_bridge_rd` in 1, `a2_bridge_wr` in 1, `a2_bridge_bus_d_oe` in 1: inputs from the card.
- `bridge_d_i` in 8, `bridge_d_o` out 8, `bridge_d_oe` out 1: split tristate; the IOBUF sits in the bench top.
- `resp_valid` out 1: one-clk pulse.
- `resp_addr` out 16, `resp_rw_n` out 1, `resp_data` out 8, `resp_driven` out 1: completed-cycle record.
- `contention` out 1: sticky flag.

## Operation
- **Timebase**
  - Counter `c7` counts 0..HALF_7M_CLKS-1. On wrap, `a2_7M` toggles and half-phase counter `hp` (0..13) advances.
  - `a2_phi1` = 1 for hp 0..6 and 0 for hp 7..13, so one phi cycle is 7 `a2_7M` periods.
- **Cycle start** (hp 13→0, phi1 rising)
  - If the FIFO is non-empty, pop the head into the current-cycle register `cur`.
  - Otherwise load `cur` = {IDLE_ADDR, rw_n=1, data=8'hFF}.
- **Bridge read** (registered)
  - Each clk, if `a2_bridge_rd`=1 and `a2_bridge_bus_d_oe`=0, set `bridge_d_oe`=1 and drive `bridge_d_o` by the previous clk's `sel`:
    - 0: addr[7:0]
    - 1: addr[15:8]
    - 2: `cur.data`
    - 3: {dip_switches_n, 1'b1, 1'b1, a2_reset_n, cur.rw_n}
  - Otherwise `bridge_d_oe`=0.
- **Card drive capture**
  - During phi0 (hp 7..13), if `a2_bridge_wr` and `a2_bridge_bus_d_oe` are both 1 and `cur.rw_n`=1: latch `bridge_d_i` into `cap_data` and set `cap_driven`.
  - Both are cleared at cycle start.
- **Response**
  - At cycle start, before `cur` is overwritten, pulse `resp_valid` with the outgoing `cur` fields.
  - `resp_data` = `cap_driven` ? `cap_data` : `cur.data`.
  - Idle cycles also report.
- **Contention**
  - Set if `bridge_d_oe` and `a2_bridge_bus_d_oe` are both 1 in the same clk, or if the card drives during a write cycle.
  - Cleared only by `reset`.
- **Reset FSM** (states IDLE → ASSERT → IDLE)
  - `reset_req` moves IDLE→ASSERT; `a2_reset_n`=0 for RESET_PHI_CYCLES full phi cycles, counted at cycle starts.
  - A `reset_req` during ASSERT restarts the count.
  - The FIFO is not flushed; cycles continue to replay during reset.

## Timing
- Reset values:
  - `a2_7M`=0, `a2_phi1`=1, hp=0, c7=0.
  - `a2_reset_n`=1, `bridge_d_oe`=0, `bridge_d_o`=0.
  - `resp_valid`=0, `resp_*`=0, `contention`=0.
  - FIFO empty, `cmd_ready`=1.
  - `cur` = idle cycle.
- `cmd_ready` = !full. A push and a pop in the same clk while full are allowed, and the count is unchanged. A pop when empty never underflows.
- Bridge read latency: 1 clk from `sel`/`rd` to `bridge_d_o`.
- `resp_valid` asserts in the same clk that `a2_phi1` rises. First `resp_valid` comes 14·HALF_7M_CLKS clks after reset release.
- Phi period = 14·HALF_7M_CLKS clks (56 at default).

## Structure
- `a2_bridge_pkg`: `bridge_sel_t` enum (ADDR_LO=0, ADDR_HI=1, DATA=2, CTRL=3), `bus_cycle_t` packed struct {addr[15:0], rw_n, data[7:0]}, control-byte bit positions.
- Sub-module `a2_cycle_fifo`: synchronous FIFO of `bus_cycle_t` with count-based full/empty.

## Test plan
- Reset release → first `a2_phi1` rise after 56 clks. `a2_7M` toggles every 4 clks; `a2_phi1` is high for 28 clks and low for 28 clks.
- Push {C0A5, rw_n=0, 3C}; card reads sel 0/1/2 → `bridge_d_o` = A5, C0, 3C, each 1 clk after `sel`. `resp` = {C0A5, 0, 3C, driven=0}.
- Push read {C0B0, rw_n=1, FF}; card pulses wr+bus_d_oe with 5A in phi0 → `resp_data`=5A, `resp_driven`=1, `contention`=0.
- Push 17 commands with FIFO_DEPTH=16 and no pops → `cmd_ready`=0 after 16. The 17th is accepted only after the next cycle-start pop. Order is preserved in `resp_addr`.
- Empty FIFO → `resp_addr`=FFFF, `rw_n`=1, `data`=FF every phi cycle.
- `reset_req` → `a2_reset_n` low for exactly 8 cycle starts. A second `reset_req` at count 5 extends it to 8 from that point. CTRL byte bit1 reads 0 while low. Card driving during a write cycle sets `contention`, which stays set.
